// File: rtl/mode7_out_writer_pkg.sv
// Shared definitions for the mode-7 output writer: element width, FSM states and
// the beats-per-vector derivation from the SRAM write width.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

package mode7_out_writer_pkg;

    localparam int DW     = `DATAWIDTH;
    localparam int NLANES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nb_of(input int wr_lanes);
        return NLANES / wr_lanes;
    endfunction

    // A single-beat configuration still carries a 1-bit beat index.
    function automatic int beat_w(input int wr_lanes);
        return (NLANES / wr_lanes > 1) ? $clog2(NLANES / wr_lanes) : 1;
    endfunction

endpackage

// File: rtl/mode7_beat_mux.sv
// Picks the WR_LANES consecutive lanes of the 8-lane hold register that form
// beat i_beat; lane k of the beat is element i_beat*WR_LANES+k.
module mode7_beat_mux
    import mode7_out_writer_pkg::*;
#(
    parameter int WR_LANES = 8,
    parameter int BW       = 1
)
(
    input  logic [DW-1:0]          i_hold [NLANES],
    input  logic [BW-1:0]          i_beat,
    output logic [WR_LANES*DW-1:0] o_data
);

    genvar gi;
    generate
        for (gi = 0; gi < WR_LANES; gi++) begin : g_lane
            logic [2:0] w_idx;
            assign w_idx = 3'((32'(i_beat) * WR_LANES) + gi);
            assign o_data[gi*DW +: DW] = i_hold[w_idx];
        end
    endgenerate

endmodule

// File: rtl/mode7_out_writer.sv
// Final softmax stage: captures 8-lane exp vectors and streams them to the output
// SRAM as NB beats at consecutive addresses, pulsing o_done after the last vector.
module mode7_out_writer
    import mode7_out_writer_pkg::*;
#(
    parameter int WR_LANES = 8,
    parameter int ADDRW    = 10,
    parameter int CNTW     = 10
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [ADDRW-1:0]       i_base_addr,
    input  logic [CNTW-1:0]        i_num_vecs,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [DW-1:0]          i_inp0,
    input  logic [DW-1:0]          i_inp1,
    input  logic [DW-1:0]          i_inp2,
    input  logic [DW-1:0]          i_inp3,
    input  logic [DW-1:0]          i_inp4,
    input  logic [DW-1:0]          i_inp5,
    input  logic [DW-1:0]          i_inp6,
    input  logic [DW-1:0]          i_inp7,
    output logic                   o_wr_en,
    input  logic                   i_wr_ready,
    output logic [ADDRW-1:0]       o_wr_addr,
    output logic [WR_LANES*DW-1:0] o_wr_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int NB = nb_of(WR_LANES);
    localparam int BW = beat_w(WR_LANES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    state_e           r_state, w_state_next;
    logic [ADDRW-1:0] r_addr;
    logic [CNTW-1:0]  r_num, r_accepted, r_written;
    logic [BW-1:0]    r_beat;
    logic             r_hold_valid;
    logic [DW-1:0]    r_hold  [NLANES];
    logic [DW-1:0]    w_lanes [NLANES];
    logic             w_beat_acc, w_last_beat, w_vec_done, w_capture;

    assign w_lanes[0] = i_inp0;
    assign w_lanes[1] = i_inp1;
    assign w_lanes[2] = i_inp2;
    assign w_lanes[3] = i_inp3;
    assign w_lanes[4] = i_inp4;
    assign w_lanes[5] = i_inp5;
    assign w_lanes[6] = i_inp6;
    assign w_lanes[7] = i_inp7;

    assign w_beat_acc  = r_hold_valid && i_wr_ready;
    assign w_last_beat = (r_beat == LAST_BEAT);
    assign w_vec_done  = w_beat_acc && w_last_beat;
    // Refill in the same cycle the last beat drains, so vectors stream without a bubble.
    assign o_in_ready  = (r_state == RUN) && (r_accepted < r_num) && (!r_hold_valid || w_vec_done);
    assign w_capture   = i_in_valid && o_in_ready;

    assign o_wr_en   = r_hold_valid;
    assign o_wr_addr = r_addr;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE);

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_hold
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold[gi] <= '0;
                end else if (w_capture) begin
                    r_hold[gi] <= w_lanes[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_num        <= '0;
            r_accepted   <= '0;
            r_written    <= '0;
            r_beat       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && i_start) begin
                r_num      <= i_num_vecs;
                r_addr     <= i_base_addr;
                r_accepted <= '0;
                r_written  <= '0;
            end
            if (w_beat_acc) begin
                r_addr <= r_addr + ADDRW'(1);
                r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
                if (w_last_beat) begin
                    r_written <= r_written + CNTW'(1);
                end
            end
            if (w_capture) begin
                r_hold_valid <= 1'b1;
                r_beat       <= '0;
                r_accepted   <= r_accepted + CNTW'(1);
            end else if (w_vec_done) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = (i_num_vecs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_vec_done && (r_written == r_num - CNTW'(1))) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    mode7_beat_mux #(
        .WR_LANES (WR_LANES),
        .BW       (BW)
    ) u_beat_mux (
        .i_hold (r_hold),
        .i_beat (r_beat),
        .o_data (o_wr_data)
    );

endmodule

// File: tb/tb_mode7_out_writer.sv
// Randomized scoreboard bench for mode7_out_writer with 4-lane SRAM beats.
// The driver predicts SRAM writes per accepted vector; a negedge monitor checks them.
module tb_mode7_out_writer;
    import mode7_out_writer_pkg::*;

    localparam int WRL   = 4;
    localparam int ADDRW = 10;
    localparam int CNTW  = 10;
    localparam int NBT   = 8 / WRL;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_start;
    logic [ADDRW-1:0]     i_base_addr;
    logic [CNTW-1:0]      i_num_vecs;
    logic                 i_in_valid;
    logic                 o_in_ready;
    logic [DW-1:0]        inp [8];
    logic                 o_wr_en;
    logic                 i_wr_ready;
    logic [ADDRW-1:0]     o_wr_addr;
    logic [WRL*DW-1:0]    o_wr_data;
    logic                 o_busy;
    logic                 o_done;

    mode7_out_writer #(
        .WR_LANES (WRL),
        .ADDRW    (ADDRW),
        .CNTW     (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_num_vecs  (i_num_vecs),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_inp0      (inp[0]),
        .i_inp1      (inp[1]),
        .i_inp2      (inp[2]),
        .i_inp3      (inp[3]),
        .i_inp4      (inp[4]),
        .i_inp5      (inp[5]),
        .i_inp6      (inp[6]),
        .i_inp7      (inp[7]),
        .o_wr_en     (o_wr_en),
        .i_wr_ready  (i_wr_ready),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDRW-1:0]  addr;
        logic [WRL*DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   words_popped = 0;
    int   job_total = 0;
    int   exp_done_at = -1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops expected writes on every accepted beat, checks stall stability and done timing.
    logic             prev_stall = 1'b0;
    logic [ADDRW-1:0] prev_addr;
    logic [WRL*DW-1:0] prev_data;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check(o_wr_en, "stall_wr_en_held", 64'(o_wr_en), 64'd1);
                check(o_wr_addr == prev_addr, "stall_addr_frozen", 64'(o_wr_addr), 64'(prev_addr));
                check(o_wr_data == prev_data, "stall_data_frozen", o_wr_data, prev_data);
            end
            if (o_wr_en && !i_wr_ready)
                check(!o_in_ready, "stall_in_ready_low", 64'(o_in_ready), 64'd0);
            if (o_wr_en && i_wr_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_write", 64'(o_wr_addr), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check(o_wr_addr == mon_e.addr, "wr_addr", 64'(o_wr_addr), 64'(mon_e.addr));
                    check(o_wr_data == mon_e.data, "wr_data", o_wr_data, mon_e.data);
                    $display("write addr=0x%03h data=0x%016h", o_wr_addr, o_wr_data);
                    words_popped++;
                    if (words_popped == job_total) exp_done_at = cyc + 1;
                end
            end
            if (o_done || cyc == exp_done_at) begin
                check(o_done == (cyc == exp_done_at), "done_timing", 64'(o_done), 64'(cyc == exp_done_at));
                if (o_done) begin
                    check(o_busy, "busy_during_done", 64'(o_busy), 64'd1);
                    check(sb.size() == 0, "done_queue_empty", 64'(sb.size()), 64'd0);
                end
            end
            prev_stall = o_wr_en && !i_wr_ready;
            prev_addr  = o_wr_addr;
            prev_data  = o_wr_data;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check(!o_in_ready, {tag, "_in_ready"}, 64'(o_in_ready), 64'd0);
        check(!o_wr_en,    {tag, "_wr_en"},    64'(o_wr_en),    64'd0);
        check(!o_busy,     {tag, "_busy"},     64'(o_busy),     64'd0);
        check(!o_done,     {tag, "_done"},     64'(o_done),     64'd0);
        check(o_wr_addr == '0, {tag, "_wr_addr"}, 64'(o_wr_addr), 64'd0);
        check(o_wr_data == '0, {tag, "_wr_data"}, o_wr_data, 64'd0);
    endtask

    // full: in_valid and wr_ready held high with patterned lanes; abort: reset mid vector 2.
    task automatic run_job(input int base, input int num, input bit full, input bit abort);
        int   acc = 0;
        int   last_cap = -1;
        int   stall_cnt = 0;
        bit   got_done = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_base_addr = ADDRW'(base);
        i_num_vecs  = CNTW'(num);
        i_in_valid  = 1'b1;
        i_wr_ready  = 1'b1;
        for (int i = 0; i < 8; i++) inp[i] = DW'($urandom);
        @(negedge clk);
        job_total    = num * NBT;
        words_popped = 0;
        if (num == 0) exp_done_at = cyc + 1;
        check(!o_in_ready, "in_ready_idle", 64'(o_in_ready), 64'd0);
        $display("job base=0x%03h num=%0d full=%0d abort=%0d", base, num, full, abort);
        for (int t = 0; t < 3000 && !got_done; t++) begin
            @(posedge clk); #1;
            i_start     = !full && ($urandom_range(0, 15) == 0);
            i_base_addr = ADDRW'($urandom);
            i_num_vecs  = CNTW'($urandom);
            i_in_valid  = full ? 1'b1 : ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 8; i++)
                inp[i] = full ? DW'(16'h3C00 + 8 * acc + i) : DW'($urandom);
            if (full) begin
                i_wr_ready = 1'b1;
            end else if (stall_cnt > 0) begin
                i_wr_ready = 1'b0;
                stall_cnt--;
            end else if ($urandom_range(0, 9) == 0) begin
                i_wr_ready = 1'b0;
                stall_cnt  = 4;
            end else begin
                i_wr_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (o_done) got_done = 1'b1;
            if (i_in_valid && acc >= num)
                check(!o_in_ready, "in_ready_after_num", 64'(o_in_ready), 64'd0);
            if (i_in_valid && o_in_ready && acc < num) begin
                for (int b = 0; b < NBT; b++) begin
                    e.addr = ADDRW'((base + acc * NBT + b) % (1 << ADDRW));
                    for (int k = 0; k < WRL; k++) e.data[k*DW +: DW] = inp[b * WRL + k];
                    sb.push_back(e);
                end
                if (full && last_cap >= 0)
                    check(cyc - last_cap == NBT, "zero_bubble_spacing", 64'(cyc - last_cap), 64'(NBT));
                last_cap = cyc;
                acc++;
            end
            if (abort && words_popped >= 2 * NBT + 1) begin
                @(posedge clk); #2;
                rst = 1'b1;
                #1;
                check_zero_outputs("async_reset");
                sb.delete();
                job_total   = 0;
                exp_done_at = -1;
                @(posedge clk); @(posedge clk); #1;
                rst        = 1'b0;
                i_start    = 1'b0;
                i_in_valid = 1'b0;
                return;
            end
        end
        if (!got_done) check(1'b0, "done_timeout", 64'd0, 64'd1);
        check(acc == num, "vectors_accepted", 64'(acc), 64'(num));
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_in_valid = 1'b1;
        @(negedge clk);
        check(!o_busy, "busy_after_done", 64'(o_busy), 64'd0);
        check(!o_in_ready, "in_ready_after_done", 64'(o_in_ready), 64'd0);
        i_in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_num_vecs  = '0;
        i_in_valid  = 1'b0;
        i_wr_ready  = 1'b1;
        for (int i = 0; i < 8; i++) inp[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        rst = 1'b0;
        // in_valid while idle must be ignored
        i_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check(!o_in_ready, "idle_in_ready", 64'(o_in_ready), 64'd0);
            check(!o_wr_en, "idle_wr_en", 64'(o_wr_en), 64'd0);
        end
        i_in_valid = 1'b0;

        run_job(32'h010, 3, 1'b1, 1'b0);
        run_job(32'h3FF, 2, 1'b1, 1'b0);
        run_job(32'h100, 0, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 1023), $urandom_range(1, 6), 1'b0, 1'b0);
        run_job(32'h200, 4, 1'b1, 1'b1);
        run_job(32'h020, 3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
